// File: rtl/comp_result_monitor_if.sv
// Sample/status bundle between the comparator result monitor and its neighbours.
// The producer/control side uses master; the monitor uses slave.
interface comp_result_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic [2:0]       y;
    logic             clr;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [2:0]       last_y;
    logic [CNT_W-1:0] run_cnt;
    logic             run_hit;
    logic             run_active;
    logic             sat;
    logic             err;

    modport master (
        output in_valid, y, clr,
        input  gt_cnt, eq_cnt, lt_cnt, last_y, run_cnt, run_hit, run_active, sat, err
    );

    modport slave (
        input  in_valid, y, clr,
        output gt_cnt, eq_cnt, lt_cnt, last_y, run_cnt, run_hit, run_active, sat, err
    );
endinterface

// File: rtl/comp_result_monitor.sv
// Monitors the one-hot comparator result stream: saturating event counters,
// run-length tracking of identical results, and sticky saturation/error flags.
module comp_result_monitor #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RUN_LEN = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    comp_result_monitor_if.slave mon
);
    typedef enum logic [1:0] {StIdle, StRun, StHit} state_e;

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RunLenC = CNT_W'(RUN_LEN);
    localparam bit               LenOne  = (RUN_LEN == 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] run_inc;
    logic [2:0]       last_y_q, last_y_d;
    logic             run_hit_q, run_hit_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;
    logic             legal;

    assign legal   = (mon.y == 3'b100) || (mon.y == 3'b010) || (mon.y == 3'b001);
    assign run_inc = run_cnt_q + CntOne;

    always_comb begin
        state_d   = state_q;
        gt_cnt_d  = gt_cnt_q;
        eq_cnt_d  = eq_cnt_q;
        lt_cnt_d  = lt_cnt_q;
        run_cnt_d = run_cnt_q;
        last_y_d  = last_y_q;
        run_hit_d = 1'b0;
        sat_d     = sat_q;
        err_d     = err_q;

        if (mon.clr) begin
            state_d   = StIdle;
            gt_cnt_d  = '0;
            eq_cnt_d  = '0;
            lt_cnt_d  = '0;
            run_cnt_d = '0;
            last_y_d  = 3'b000;
            sat_d     = 1'b0;
            err_d     = 1'b0;
        end else if (mon.in_valid) begin
            if (!legal) begin
                err_d     = 1'b1;
                last_y_d  = 3'b000;
                run_cnt_d = '0;
                state_d   = StIdle;
            end else begin
                unique case (mon.y)
                    3'b100: if (gt_cnt_q == CntMax) sat_d = 1'b1; else gt_cnt_d = gt_cnt_q + CntOne;
                    3'b010: if (eq_cnt_q == CntMax) sat_d = 1'b1; else eq_cnt_d = eq_cnt_q + CntOne;
                    3'b001: if (lt_cnt_q == CntMax) sat_d = 1'b1; else lt_cnt_d = lt_cnt_q + CntOne;
                    default: ;
                endcase

                // last_y is 000 in IDLE, so a legal code always starts a new run there
                if (state_q == StIdle || mon.y != last_y_q) begin
                    last_y_d  = mon.y;
                    run_cnt_d = CntOne;
                    state_d   = LenOne ? StHit : StRun;
                    run_hit_d = LenOne;
                end else if (state_q == StRun) begin
                    run_cnt_d = run_inc;
                    if (run_inc == RunLenC) begin
                        state_d   = StHit;
                        run_hit_d = 1'b1;
                    end
                end else if (run_cnt_q == CntMax) begin
                    sat_d = 1'b1;
                end else begin
                    run_cnt_d = run_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gt_cnt_q  <= '0;
            eq_cnt_q  <= '0;
            lt_cnt_q  <= '0;
            run_cnt_q <= '0;
            last_y_q  <= 3'b000;
            run_hit_q <= 1'b0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gt_cnt_q  <= gt_cnt_d;
            eq_cnt_q  <= eq_cnt_d;
            lt_cnt_q  <= lt_cnt_d;
            run_cnt_q <= run_cnt_d;
            last_y_q  <= last_y_d;
            run_hit_q <= run_hit_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
        end
    end

    assign mon.gt_cnt     = gt_cnt_q;
    assign mon.eq_cnt     = eq_cnt_q;
    assign mon.lt_cnt     = lt_cnt_q;
    assign mon.run_cnt    = run_cnt_q;
    assign mon.last_y     = last_y_q;
    assign mon.run_hit    = run_hit_q;
    assign mon.run_active = (state_q == StHit);
    assign mon.sat        = sat_q;
    assign mon.err        = err_q;
endmodule

// File: tb/tb_comp_result_monitor.sv
// Directed bench for comp_result_monitor: an 8-bit instance for run/error/reset
// behaviour and a 4-bit instance for counter saturation and clr priority.
module tb_comp_result_monitor;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    comp_result_monitor_if #(.CNT_W(8)) a8 ();
    comp_result_monitor_if #(.CNT_W(4)) a4 ();

    comp_result_monitor #(.CNT_W(8), .RUN_LEN(4)) dut8 (.clk(clk), .rst_n(rst_n), .mon(a8));
    comp_result_monitor #(.CNT_W(4), .RUN_LEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .mon(a4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input int gt, input int eq, input int lt,
                        input int ly, input int rc, input int hit, input int act,
                        input int sat, input int err);
        chk({tag, ".gt"},  32'(a8.gt_cnt),     32'(gt));
        chk({tag, ".eq"},  32'(a8.eq_cnt),     32'(eq));
        chk({tag, ".lt"},  32'(a8.lt_cnt),     32'(lt));
        chk({tag, ".ly"},  32'(a8.last_y),     32'(ly));
        chk({tag, ".rc"},  32'(a8.run_cnt),    32'(rc));
        chk({tag, ".hit"}, 32'(a8.run_hit),    32'(hit));
        chk({tag, ".act"}, 32'(a8.run_active), 32'(act));
        chk({tag, ".sat"}, 32'(a8.sat),        32'(sat));
        chk({tag, ".err"}, 32'(a8.err),        32'(err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [2:0] yy, input logic c);
        a8.in_valid = v;
        a8.y        = yy;
        a8.clr      = c;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        a8.in_valid = 1'b0; a8.y = 3'b000; a8.clr = 1'b0;
        a4.in_valid = 1'b0; a4.y = 3'b000; a4.clr = 1'b0;
        tick();
        tick();
        chk8("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: one of each code, no run forms
        drive8(1'b1, 3'b010, 1'b0);
        chk8("t1_eq", 0, 1, 0, 2, 1, 0, 0, 0, 0);
        drive8(1'b1, 3'b100, 1'b0);
        chk8("t1_gt", 1, 1, 0, 4, 1, 0, 0, 0, 0);
        drive8(1'b1, 3'b001, 1'b0);
        chk8("t1_lt", 1, 1, 1, 1, 1, 0, 0, 0, 0);

        drive8(1'b0, 3'b000, 1'b1);
        chk8("clr8", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Test 2: four 100s interleaved with idle cycles; pulse only after the 4th
        for (int i = 0; i < 7; i++) begin
            drive8((i % 2) == 0, 3'b100, 1'b0);
            chk("t2_hit", 32'(a8.run_hit), (i == 6) ? 32'd1 : 32'd0);
        end
        chk8("t2_after4", 4, 0, 0, 4, 4, 1, 1, 0, 0);
        drive8(1'b0, 3'b100, 1'b0);
        chk8("t2_hold", 4, 0, 0, 4, 4, 0, 1, 0, 0);

        // Test 3: run extends past RUN_LEN without another pulse, then breaks
        drive8(1'b1, 3'b100, 1'b0);
        chk8("t3_fifth", 5, 0, 0, 4, 5, 0, 1, 0, 0);
        drive8(1'b1, 3'b010, 1'b0);
        chk8("t3_break", 5, 1, 0, 2, 1, 0, 0, 0, 0);

        // Test 4: illegal codes
        drive8(1'b1, 3'b110, 1'b0);
        chk8("t4_110", 5, 1, 0, 0, 0, 0, 0, 0, 1);
        drive8(1'b1, 3'b000, 1'b0);
        chk8("t4_000", 5, 1, 0, 0, 0, 0, 0, 0, 1);
        drive8(1'b1, 3'b001, 1'b0);
        chk8("t4_sticky", 5, 1, 1, 1, 1, 0, 0, 0, 1);

        // Test 5: 4-bit instance saturates; clr beats a simultaneous sample
        a8.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a4.in_valid = 1'b1; a4.y = 3'b001; a4.clr = 1'b0;
            tick();
        end
        chk("t5_lt",  32'(a4.lt_cnt),     32'd15);
        chk("t5_rc",  32'(a4.run_cnt),    32'd15);
        chk("t5_sat", 32'(a4.sat),        32'd1);
        chk("t5_act", 32'(a4.run_active), 32'd1);
        chk("t5_gt",  32'(a4.gt_cnt),     32'd0);
        a4.in_valid = 1'b1; a4.y = 3'b001; a4.clr = 1'b1;
        tick();
        a4.in_valid = 1'b0; a4.clr = 1'b0;
        chk("t5c_lt",  32'(a4.lt_cnt),     32'd0);
        chk("t5c_rc",  32'(a4.run_cnt),    32'd0);
        chk("t5c_ly",  32'(a4.last_y),     32'd0);
        chk("t5c_sat", 32'(a4.sat),        32'd0);
        chk("t5c_hit", 32'(a4.run_hit),    32'd0);
        chk("t5c_act", 32'(a4.run_active), 32'd0);
        chk("t5c_err", 32'(a4.err),        32'd0);

        // Test 6: async reset mid-run while run_active is high
        drive8(1'b1, 3'b001, 1'b0);
        drive8(1'b1, 3'b001, 1'b0);
        drive8(1'b1, 3'b001, 1'b0);
        a8.in_valid = 1'b0;
        chk8("t6_pre", 5, 1, 4, 1, 4, 1, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("t6_async", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        drive8(1'b1, 3'b010, 1'b0);
        chk8("t6_new", 0, 1, 0, 2, 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
